eth_rx: RTL and testbench
=========================

# eth_rx

RGMII receive path: the inbound counterpart to the frame transmitter on the same link. Captures DDR nibbles on the 125 MHz receive clock and strips preamble/SFD. Checks destination MAC, the team ethertype 0x1919 and the FCS, extracts the 16-bit sequence number, and writes the 1024-byte payload into a ping-pong buffer (two banks of 1024 bytes). The bank index is handed to the consumer only after a frame is fully validated.

## Interface
- MAC, 48'h00_88da_b8bf_08: local address; wire order is the low byte first (08 bf b8 da 88 00). Broadcast ff..ff is also accepted.
- ETYPE, 16'h1919: required ethertype, high byte first on the wire.
- clk125  in  1  receive clock (RGMII RXC); one clock. All state updates on posedge except the DDR high-nibble capture.
- rstn  in  1  synchronous, active-low reset.
- rxctl  in  1  RGMII RX_CTL: DV at the rising edge, DV^ER at the falling edge.
- rxd  in  4  RGMII data: low nibble at the rising edge, high nibble at the falling edge.
- wren  out  1  payload write strobe.
- wrad  out  11  write address {bank, offset[9:0]}.
- wrdata  out  8  payload byte.
- rdidx  out  1  bank holding the most recent good frame.
- seq  out  16  sequence number of the most recent good frame.
- frm_ok  out  1  one-cycle pulse when a good frame is committed.
- frm_bad  out  1  one-cycle pulse when a frame that passed SFD is rejected.

## Operation
- DDR stage: capture the low nibble and DV at posedge, and the high nibble and DV^ER at negedge. At the next posedge, present byte {hi, lo}, dv, and er = dv ^ (DV^ER).
- FSM states: IDLE, PRE, HDR, PAY, FCS, TAIL, DROP.
- IDLE: a byte with dv=1 and value 0x55 goes to PRE; 0xD5 goes to HDR; any other dv byte goes to DROP.
- PRE: 0x55 stays in PRE; 0xD5 goes to HDR; anything else goes to DROP.
- Byte counter cnt (11 bit) counts bytes after SFD, starting at 0.
- HDR, cnt 0..15:
  - bytes 0-5 are dst, compared with MAC or broadcast;
  - bytes 6-11 are src, ignored;
  - bytes 12-13 are the ethertype, compared with ETYPE;
  - bytes 14-15 are seq, low byte first, held in a shadow register.
- PAY, cnt 16..1039: wren=1, wrad={~rdidx, cnt-16}, wrdata=byte.
- FCS, cnt 1040..1043, then go to TAIL.
- CRC:
  - reflected CRC-32, polynomial 0xEDB88320, LSB first;
  - register initialised to 0xFFFFFFFF at SFD;
  - updated on every byte from cnt 0 through 1043, including the FCS;
  - pass means register == 0xDEBB20E3 after byte 1043.
- TAIL:
  - the next byte slot must have dv=0;
  - if the header matched and the CRC passed: set rdidx <= ~rdidx, copy the seq shadow to seq, pulse frm_ok, go to IDLE;
  - otherwise pulse frm_bad and go to IDLE.
- Errors: dv=1 in the TAIL slot (oversize), dv falling before TAIL (short frame), or er=1 at any byte after SFD. Each gives frm_bad immediately and moves to DROP; payload writes stop.
- Header mismatch does not abort the frame. Reception continues to the end of the frame, writes land in the inactive bank, and frm_bad is pulsed in TAIL.
- DROP: wait for dv=0, then go to IDLE. DROP issues no additional frm_bad.
- A rejected frame never changes rdidx or seq. The inactive bank is overwritten by the next frame.

## Timing
- Reset values: wren=0, wrad=0, wrdata=0, rdidx=0, seq=0, frm_ok=0, frm_bad=0, FSM in IDLE, CRC register 0xFFFFFFFF.
- DDR to byte: one posedge after the high nibble is captured.
- Outputs are registered. wren/wrad/wrdata for a payload byte appear one clk125 cycle after that byte is presented.
- frm_ok/frm_bad are asserted in the cycle after the TAIL slot. rdidx and seq update in the same cycle as frm_ok.
- Reset mid-frame: return immediately to reset values. If dv is still high after reset release, go to DROP (no pulse) until dv=0.
- Back-to-back frames with minimum IFG (12 idle bytes) are fully supported; IDLE needs zero gap cycles.

## Structure
- Shared package `eth_pkg`:
  - crc32 byte-update function (the same one the transmitter uses);
  - MAC;
  - ETYPE;
  - PAYLOAD_LEN=1024;
  - HDR_LEN=16;
  - CRC_RESIDUE=32'hDEBB20E3;
  - FSM state enum.
- Sub-module `rgmii_rx_ddr`: negedge/posedge capture that outputs byte, dv and er on posedge. All remaining logic lives in eth_rx.

## Test plan
- Good frame: 7×0x55, 0xD5, dst 08 bf b8 da 88 00, ethertype 19 19, seq 34 12, payload k&0xFF, correct FCS. Expect 1024 writes at wrad 0x400..0x7FF, frm_ok, rdidx=1, seq=0x1234.
- Two back-to-back good frames with seq 1 and 2 and a 12-byte IFG. Expect the second frame to write 0x000..0x3FF, rdidx=0, seq=2.
- FCS with one bit flipped in the last byte. Expect frm_bad, rdidx and seq unchanged.
- dst byte 0 = 0x09, otherwise valid. Expect writes to occur, then frm_bad, rdidx unchanged. The same frame with dst ff×6 gives frm_ok.
- RX_ER asserted on payload byte 100. Expect wren to stop after 100 writes, a single frm_bad, and DROP until dv falls.
- dv deasserted after 1000 bytes (short frame), and separately one extra byte after the FCS (oversize). Expect frm_bad in both cases. Also apply rstn low mid-payload: all outputs must be 0 and the next valid frame must give frm_ok.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared definitions for the team Ethernet link: addresses, frame geometry,
// receive FSM states and the reflected CRC-32 byte update.
package eth_pkg;

  localparam logic [47:0] MAC         = 48'h00_88da_b8bf_08;
  localparam logic [15:0] ETYPE       = 16'h1919;
  localparam int          PAYLOAD_LEN = 1024;
  localparam int          HDR_LEN     = 16;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;

  typedef enum logic [2:0] {
    IDLE, PRE, HDR, PAY, FCS, TAIL, DROP
  } rx_state_t;

  // LSB-first update, identical to the transmitter's
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] r;
    r = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/rgmii_rx_ddr.sv
// RGMII receive DDR capture: low nibble/DV on the rising edge, high nibble and
// DV^ER on the falling edge, presented as one byte at the following rising edge.
module rgmii_rx_ddr (
  input  logic       clk,
  input  logic       rxctl,
  input  logic [3:0] rxd,
  output logic [7:0] data,
  output logic       dv,
  output logic       er
);

  logic [3:0] lo_nib;
  logic [3:0] hi_nib;
  logic       dv_rise;
  logic       dv_fall;

  // No reset: the capture keeps tracking the line so a frame still in flight
  // is visible to the FSM the moment reset is released.
  always_ff @(posedge clk) begin
    lo_nib  <= rxd;
    dv_rise <= rxctl;
    data    <= {hi_nib, lo_nib};
    dv      <= dv_rise;
    er      <= dv_rise ^ dv_fall;
  end

  always_ff @(negedge clk) begin
    hi_nib  <= rxd;
    dv_fall <= rxctl;
  end

endmodule

// File: rtl/eth_rx.sv
// Receive path: strips preamble/SFD, checks header and FCS, writes the payload
// into the inactive half of a ping-pong buffer and commits the bank on success.
module eth_rx
  import eth_pkg::*;
(
  input  logic        clk125,
  input  logic        rstn,
  input  logic        rxctl,
  input  logic [3:0]  rxd,
  output logic        wren,
  output logic [10:0] wrad,
  output logic [7:0]  wrdata,
  output logic        rdidx,
  output logic [15:0] seq,
  output logic        frm_ok,
  output logic        frm_bad
);

  localparam logic [10:0] HDR_END = 11'(HDR_LEN - 1);
  localparam logic [10:0] PAY_END = 11'(HDR_LEN + PAYLOAD_LEN - 1);
  localparam logic [10:0] FCS_END = 11'(HDR_LEN + PAYLOAD_LEN + 3);

  logic [7:0]  data;
  logic        dv;
  logic        er;
  rx_state_t   state;
  logic [10:0] cnt;
  logic [31:0] crc;
  logic [15:0] seq_sh;
  logic        dst_mac;
  logic        dst_bc;
  logic        etype_ok;
  logic        dv_prev;

  rgmii_rx_ddr u_ddr (
    .clk   (clk125),
    .rxctl (rxctl),
    .rxd   (rxd),
    .data  (data),
    .dv    (dv),
    .er    (er)
  );

  // dv_prev resets high so a frame already in progress at reset release is dropped
  always_ff @(posedge clk125) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      crc      <= CRC_INIT;
      seq_sh   <= '0;
      dst_mac  <= 1'b1;
      dst_bc   <= 1'b1;
      etype_ok <= 1'b1;
      dv_prev  <= 1'b1;
      wren     <= 1'b0;
      wrad     <= '0;
      wrdata   <= '0;
      rdidx    <= 1'b0;
      seq      <= '0;
      frm_ok   <= 1'b0;
      frm_bad  <= 1'b0;
    end else begin
      wren    <= 1'b0;
      frm_ok  <= 1'b0;
      frm_bad <= 1'b0;
      dv_prev <= dv;
      case (state)
        IDLE, PRE: begin
          cnt      <= '0;
          crc      <= CRC_INIT;
          dst_mac  <= 1'b1;
          dst_bc   <= 1'b1;
          etype_ok <= 1'b1;
          if (state == IDLE && !dv) state <= IDLE;
          else if (state == IDLE && dv_prev) state <= DROP;
          else if (dv && data == 8'h55) state <= PRE;
          else if (dv && data == 8'hD5) state <= HDR;
          else state <= DROP;
        end
        HDR, PAY, FCS: begin
          if (!dv || er) begin
            frm_bad <= 1'b1;
            state   <= DROP;
          end else begin
            crc <= crc32_byte(crc, data);
            cnt <= cnt + 11'd1;
            if (state == HDR) begin
              if (cnt < 11'd6) begin
                if (data != MAC[{cnt[2:0], 3'b000} +: 8]) dst_mac <= 1'b0;
                if (data != 8'hFF) dst_bc <= 1'b0;
              end
              if (cnt == 11'd12 && data != ETYPE[15:8]) etype_ok <= 1'b0;
              if (cnt == 11'd13 && data != ETYPE[7:0]) etype_ok <= 1'b0;
              if (cnt == 11'd14) seq_sh[7:0] <= data;
              if (cnt == HDR_END) begin
                seq_sh[15:8] <= data;
                state        <= PAY;
              end
            end else if (state == PAY) begin
              wren   <= 1'b1;
              wrad   <= {~rdidx, cnt[9:0] - 10'd16};
              wrdata <= data;
              if (cnt == PAY_END) state <= FCS;
            end else if (cnt == FCS_END) begin
              state <= TAIL;
            end
          end
        end
        TAIL: begin
          if (dv) begin
            frm_bad <= 1'b1;
            state   <= DROP;
          end else if ((dst_mac || dst_bc) && etype_ok && crc == CRC_RESIDUE) begin
            rdidx  <= ~rdidx;
            seq    <= seq_sh;
            frm_ok <= 1'b1;
            state  <= IDLE;
          end else begin
            frm_bad <= 1'b1;
            state   <= IDLE;
          end
        end
        DROP: if (!dv) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx.sv
// Randomized frame-level bench for eth_rx with a byte-queue reference model
// and a monitor that collects every payload write and status pulse.
module tb_eth_rx;

  logic        clk125 = 1'b0;
  logic        rstn   = 1'b0;
  logic        rxctl  = 1'b0;
  logic [3:0]  rxd    = 4'h0;
  logic        wren;
  logic [10:0] wrad;
  logic [7:0]  wrdata;
  logic        rdidx;
  logic [15:0] seq;
  logic        frm_ok;
  logic        frm_bad;

  eth_rx dut (
    .clk125  (clk125),
    .rstn    (rstn),
    .rxctl   (rxctl),
    .rxd     (rxd),
    .wren    (wren),
    .wrad    (wrad),
    .wrdata  (wrdata),
    .rdidx   (rdidx),
    .seq     (seq),
    .frm_ok  (frm_ok),
    .frm_bad (frm_bad)
  );

  always #4 clk125 = ~clk125;

  localparam logic [7:0] MAC_WIRE [6] = '{8'h08, 8'hbf, 8'hb8, 8'hda, 8'h88, 8'h00};

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  fb[$];
  logic [10:0] wa_q[$];
  logic [7:0]  wd_q[$];
  int          ok_cnt = 0;
  int          bad_cnt = 0;
  logic        m_rdidx = 1'b0;
  logic [15:0] m_seq = 16'h0;

  // Monitor samples on the falling edge, away from the DUT's update edge
  always @(negedge clk125) begin
    if (wren) begin
      wa_q.push_back(wrad);
      wd_q.push_back(wrdata);
    end
    if (frm_ok) ok_cnt++;
    if (frm_bad) bad_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic driveByte(input logic [7:0] b, input logic v, input logic e);
    @(negedge clk125);
    #2;
    rxd   = b[3:0];
    rxctl = v;
    @(posedge clk125);
    #2;
    rxd   = b[7:4];
    rxctl = v ^ e;
  endtask

  // Bit-serial FCS over the first n bytes of fb, complemented as transmitted
  function automatic logic [31:0] fcsOf(input int n);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (c[0] ^ fb[i][j]) c = (c >> 1) ^ 32'hEDB8_8320;
        else c = c >> 1;
      end
    end
    return ~c;
  endfunction

  // dst_mode: 0 local MAC, 1 broadcast, 2 first byte 0x09
  task automatic buildFrame(input int dst_mode, input bit bad_etype, input logic [15:0] sq,
                            input bit ramp, input bit flip);
    logic [31:0] c;
    fb.delete();
    for (int i = 0; i < 6; i++) begin
      if (dst_mode == 1) fb.push_back(8'hFF);
      else if (dst_mode == 2 && i == 0) fb.push_back(8'h09);
      else fb.push_back(MAC_WIRE[i]);
    end
    for (int i = 0; i < 6; i++) fb.push_back(8'($urandom));
    fb.push_back(8'h19);
    fb.push_back(bad_etype ? 8'h18 : 8'h19);
    fb.push_back(sq[7:0]);
    fb.push_back(sq[15:8]);
    for (int k = 0; k < 1024; k++) fb.push_back(ramp ? 8'(k) : 8'($urandom));
    c = fcsOf(1040);
    for (int j = 0; j < 4; j++) fb.push_back(c[8*j +: 8]);
    if (flip) fb[1043] = fb[1043] ^ 8'h01;
  endtask

  function automatic int clampWr(input int n);
    if (n < 16) return 0;
    if (n > 1040) return 1024;
    return n - 16;
  endfunction

  // Sends the frame in fb (n_send bytes after SFD, er on byte er_at, reset at
  // byte rst_at) plus a 12-byte gap, then checks it against the model.
  task automatic applyStimulus(input string name, input int n_send, input int er_at, input int rst_at);
    int   exp_wr, exp_ok, exp_bad, addr_err, data_err;
    bit   dst_bc, dst_mac, good;
    logic bank;
    logic [7:0] b;
    wa_q.delete();
    wd_q.delete();
    ok_cnt  = 0;
    bad_cnt = 0;
    repeat (7) driveByte(8'h55, 1'b1, 1'b0);
    driveByte(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < n_send; i++) begin
      b = (i < fb.size()) ? fb[i] : 8'($urandom);
      if (rst_at >= 0 && i == rst_at) rstn = 1'b0;
      if (rst_at >= 0 && i == rst_at + 2) rstn = 1'b1;
      driveByte(b, 1'b1, i == er_at);
      if (rst_at >= 0 && i == rst_at) begin
        checkOutput({name, "/in_reset"}, {wren, wrad, wrdata, rdidx, seq, frm_ok, frm_bad}, 64'd0);
        m_rdidx = 1'b0;
        m_seq   = 16'h0;
        wa_q.delete();
        wd_q.delete();
        ok_cnt  = 0;
        bad_cnt = 0;
      end
    end
    repeat (12) driveByte(8'h00, 1'b0, 1'b0);

    dst_bc  = 1;
    dst_mac = 1;
    for (int i = 0; i < 6; i++) begin
      if (fb[i] != 8'hFF) dst_bc = 0;
      if (fb[i] != MAC_WIRE[i]) dst_mac = 0;
    end
    good = 0;
    if (rst_at >= 0) begin
      exp_wr = 0; exp_ok = 0; exp_bad = 0;
    end else if (er_at >= 0 && er_at < n_send) begin
      exp_wr = clampWr(er_at); exp_ok = 0; exp_bad = 1;
    end else if (n_send != 1044) begin
      exp_wr = clampWr(n_send); exp_ok = 0; exp_bad = 1;
    end else begin
      good = (dst_bc || dst_mac) && fb[12] == 8'h19 && fb[13] == 8'h19 &&
             fcsOf(1040) == {fb[1043], fb[1042], fb[1041], fb[1040]};
      exp_wr  = 1024;
      exp_ok  = good ? 1 : 0;
      exp_bad = good ? 0 : 1;
    end

    bank     = ~m_rdidx;
    addr_err = 0;
    data_err = 0;
    for (int k = 0; k < wa_q.size() && k < exp_wr; k++) begin
      if (wa_q[k] !== {bank, 10'(k)}) addr_err++;
      if (wd_q[k] !== fb[16 + k]) data_err++;
    end
    if (good) begin
      m_rdidx = ~m_rdidx;
      m_seq   = {fb[15], fb[14]};
    end
    checkOutput({name, "/writes"}, wa_q.size(), exp_wr);
    checkOutput({name, "/wrad"}, addr_err, 0);
    checkOutput({name, "/wrdata"}, data_err, 0);
    checkOutput({name, "/frm_ok"}, ok_cnt, exp_ok);
    checkOutput({name, "/frm_bad"}, bad_cnt, exp_bad);
    checkOutput({name, "/rdidx"}, rdidx, m_rdidx);
    checkOutput({name, "/seq"}, seq, m_seq);
  endtask

  initial begin
    int kind;
    repeat (3) driveByte(8'h00, 1'b0, 1'b0);
    checkOutput("reset", {wren, wrad, wrdata, rdidx, seq, frm_ok, frm_bad}, 64'd0);
    rstn = 1'b1;
    repeat (4) driveByte(8'h00, 1'b0, 1'b0);

    buildFrame(0, 0, 16'h1234, 1, 0); applyStimulus("good_ramp", 1044, -1, -1);
    buildFrame(0, 0, 16'h0001, 0, 0); applyStimulus("b2b_1", 1044, -1, -1);
    buildFrame(0, 0, 16'h0002, 0, 0); applyStimulus("b2b_2", 1044, -1, -1);
    buildFrame(0, 0, 16'h0BAD, 0, 1); applyStimulus("fcs_flip", 1044, -1, -1);
    buildFrame(2, 0, 16'h0009, 0, 0); applyStimulus("dst_09", 1044, -1, -1);
    buildFrame(1, 0, 16'h00FF, 0, 0); applyStimulus("bcast", 1044, -1, -1);
    buildFrame(0, 0, 16'h0E00, 0, 0); applyStimulus("rx_er", 1044, 116, -1);
    buildFrame(0, 0, 16'h0500, 0, 0); applyStimulus("short", 1000, -1, -1);
    buildFrame(0, 0, 16'h0600, 0, 0); applyStimulus("oversize", 1045, -1, -1);
    buildFrame(0, 0, 16'h0700, 0, 0); applyStimulus("mid_reset", 1044, -1, 316);
    buildFrame(0, 0, 16'h0800, 0, 0); applyStimulus("after_reset", 1044, -1, -1);

    for (int r = 0; r < 6; r++) begin
      kind = int'($urandom_range(0, 7));
      case (kind)
        0: begin buildFrame(0, 0, 16'($urandom), 0, 0); applyStimulus("rnd_good", 1044, -1, -1); end
        1: begin buildFrame(0, 0, 16'($urandom), 0, 1); applyStimulus("rnd_fcs", 1044, -1, -1); end
        2: begin buildFrame(2, 0, 16'($urandom), 0, 0); applyStimulus("rnd_dst", 1044, -1, -1); end
        3: begin buildFrame(1, 0, 16'($urandom), 0, 0); applyStimulus("rnd_bcast", 1044, -1, -1); end
        4: begin buildFrame(0, 1, 16'($urandom), 0, 0); applyStimulus("rnd_etype", 1044, -1, -1); end
        5: begin buildFrame(0, 0, 16'($urandom), 0, 0);
                 applyStimulus("rnd_er", 1044, int'($urandom_range(0, 1043)), -1); end
        6: begin buildFrame(0, 0, 16'($urandom), 0, 0);
                 applyStimulus("rnd_short", int'($urandom_range(1, 1043)), -1, -1); end
        default: begin buildFrame(0, 0, 16'($urandom), 0, 0);
                 applyStimulus("rnd_long", int'($urandom_range(1045, 1050)), -1, -1); end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
